// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I multicycle control path: opcodes,
// controller state encoding, ALU operation classes and ALU codes.
package riscv_pkg;

    // Datapath width; documentation only, no control port depends on it.
    localparam int XLEN       = 32;
    localparam int ALU_CTRL_W = 3;

    // Supported major opcodes (instr[6:0]).
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Controller states; encodings 11..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } ctrl_state_t;

    // Operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } alu_op_t;

    // ALU operation codes, shared with the ALU itself.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/multicycle_ctrl_alu_dec.sv
// ALU decoder: maps the FSM's operation class plus funct fields to the
// 3-bit ALU code. Purely combinational.
module alu_dec
    import riscv_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_ctrl,
    output logic       bad_funct
);

    // Select the ALU code; only register-register SUB uses funct7b5, addi never does.
    always_comb begin
        alu_ctrl  = ALU_ADD;
        bad_funct = 1'b0;
        case (aluop)
            AOP_ADD: begin
                alu_ctrl = ALU_ADD;
            end
            AOP_SUB: begin
                alu_ctrl = ALU_SUB;
            end
            AOP_FUNCT: begin
                case (funct3)
                    3'b000: begin
                        if (op5 && funct7b5) begin
                            alu_ctrl = ALU_SUB;
                        end else begin
                            alu_ctrl = ALU_ADD;
                        end
                    end
                    3'b010: alu_ctrl = ALU_SLT;
                    3'b110: alu_ctrl = ALU_OR;
                    3'b111: alu_ctrl = ALU_AND;
                    default: begin
                        alu_ctrl  = ALU_ADD;
                        bad_funct = 1'b1;
                    end
                endcase
            end
            default: begin
                alu_ctrl = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset control unit: sequences fetch/decode/execute/
// memory/writeback, drives datapath selects and enables, and produces the
// ALU operation code. Outputs are decoded from state (BEQ pc_write also
// uses z); while rst is high the selects show FETCH values and every
// enable is held low.
module multicycle_ctrl
    import riscv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  z,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic                  reg_write,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic                  illegal
);

    ctrl_state_t state_r;
    ctrl_state_t next_s;
    ctrl_state_t dec_state_s;
    alu_op_t     aluop_s;
    logic        pc_write_s;
    logic        mem_write_s;
    logic        ir_write_s;
    logic        reg_write_s;
    logic        illegal_s;
    logic        bad_funct_s;

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state sequencing; unused encodings fall back to FETCH.
    always_comb begin
        next_s = S_FETCH;
        case (state_r)
            S_FETCH: next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_s = S_MEMADR;
                    OP_R:              next_s = S_EXECR;
                    OP_I:              next_s = S_EXECI;
                    OP_JAL:            next_s = S_JAL;
                    OP_BRANCH:         next_s = S_BEQ;
                    default:           next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD) begin
                    next_s = S_MEMREAD;
                end else begin
                    next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD:  next_s = S_MEMWB;
            S_MEMWB:    next_s = S_FETCH;
            S_MEMWRITE: next_s = S_FETCH;
            S_EXECR:    next_s = S_ALUWB;
            S_EXECI:    next_s = S_ALUWB;
            S_ALUWB:    next_s = S_FETCH;
            S_JAL:      next_s = S_ALUWB;
            S_BEQ:      next_s = S_FETCH;
            default:    next_s = S_FETCH;
        endcase
    end

    // Output decode; during reset the selects are taken from FETCH.
    always_comb begin
        dec_state_s = rst ? S_FETCH : state_r;
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        reg_write_s = 1'b0;
        aluop_s     = AOP_ADD;
        illegal_s   = 1'b0;
        case (dec_state_s)
            S_FETCH: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_write_s = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    OP_LOAD, OP_STORE, OP_R, OP_I, OP_JAL, OP_BRANCH: illegal_s = 1'b0;
                    default:                                          illegal_s = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                if (op == OP_LOAD) begin
                    imm_src = 2'b00;
                end else begin
                    imm_src = 2'b01;
                end
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                aluop_s   = AOP_FUNCT;
                illegal_s = bad_funct_s;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                aluop_s   = AOP_FUNCT;
                illegal_s = bad_funct_s;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                aluop_s   = AOP_SUB;
                case (funct3)
                    3'b000:  pc_write_s = z;
                    3'b001:  pc_write_s = ~z;
                    default: illegal_s  = 1'b1;
                endcase
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    alu_dec u_alu_dec (
        .aluop     (aluop_s),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .op5       (op[5]),
        .alu_ctrl  (alu_ctrl),
        .bad_funct (bad_funct_s)
    );

    assign pc_write  = pc_write_s  & ~rst;
    assign mem_write = mem_write_s & ~rst;
    assign ir_write  = ir_write_s  & ~rst;
    assign reg_write = reg_write_s & ~rst;
    assign illegal   = illegal_s   & ~rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes its
// hand-computed output vector; a monitor pops and compares on the falling edge.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       z;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_ctrl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [16:0] v;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .z          (z),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Pack expected outputs in the same order the monitor packs the DUT outputs.
    function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] imm, input logic rw,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rs, a, b, imm, rw, alu, ill};
    endfunction

    // Monitor: one output vector per cycle, compared against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [16:0] act;
            e   = sb.pop_front();
            act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                   alu_src_b, imm_src, reg_write, alu_ctrl, illegal};
            checks++;
            if (act !== e.v) begin
                errors++;
                $display("FAIL %s: got %b required %b (pcw adr mw irw rs a b imm rw alu ill)",
                         e.nm, act, e.v);
            end
        end
    end

    logic [16:0] fetch_v, reset_v, dec_v, dec_ill_v, aluwb_v;

    task automatic cyc(input string nm, input logic [16:0] v);
        exp_t e;
        e.nm = nm;
        e.v  = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic zz, input logic bad_op);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        z        = zz;
        cyc({nm, "_fetch"}, fetch_v);
        cyc({nm, "_decode"}, bad_op ? dec_ill_v : dec_v);
    endtask

    task automatic rtype(input string nm, input logic [2:0] f3, input logic f7,
                         input logic [2:0] alu, input logic ill);
        start(nm, 7'b0110011, f3, f7, 1'b0, 1'b0);
        cyc({nm, "_execr"}, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, alu, ill));
        cyc({nm, "_aluwb"}, aluwb_v);
    endtask

    task automatic branch(input string nm, input logic [2:0] f3, input logic zz,
                          input logic pcw, input logic ill);
        start(nm, 7'b1100011, f3, 1'b0, zz, 1'b0);
        cyc({nm, "_beq"}, ev(pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, ill));
    endtask

    initial begin
        fetch_v   = ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0);
        reset_v   = ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0);
        dec_v     = ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 3'b000, 1'b0);
        dec_ill_v = ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 1'b0, 3'b000, 1'b1);
        aluwb_v   = ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0);

        rst      = 1'b1;
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        z        = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset0", reset_v);
        cyc("reset1", reset_v);
        rst = 1'b0;

        // Register-register ops, including an unsupported funct3.
        rtype("sub", 3'b000, 1'b1, 3'b001, 1'b0);
        rtype("add", 3'b000, 1'b0, 3'b000, 1'b0);
        rtype("slt", 3'b010, 1'b0, 3'b101, 1'b0);
        rtype("or",  3'b110, 1'b0, 3'b011, 1'b0);
        rtype("and", 3'b111, 1'b0, 3'b010, 1'b0);
        rtype("sll_bad", 3'b001, 1'b0, 3'b000, 1'b1);

        // Load: five cycles.
        start("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc("lw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0));
        cyc("lw_memread", ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));
        cyc("lw_memwb", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b0));

        // Store: four cycles, S-type immediate.
        start("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        cyc("sw_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0));
        cyc("sw_memwrite", ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0));

        // Branches: taken/not taken for beq and bne, plus a bad funct3.
        branch("beq_z1", 3'b000, 1'b1, 1'b1, 1'b0);
        branch("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
        branch("bne_z0", 3'b001, 1'b0, 1'b1, 1'b0);
        branch("bne_z1", 3'b001, 1'b1, 1'b0, 1'b0);
        branch("blt_bad", 3'b100, 1'b1, 1'b0, 1'b1);

        // addi with instr[30] set must still add.
        start("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0);
        cyc("addi_execi", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0));
        cyc("addi_aluwb", aluwb_v);

        // jal: PC update in JAL, link write in ALUWB.
        start("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        cyc("jal_jal", ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 1'b0));
        cyc("jal_aluwb", aluwb_v);

        // Unsupported opcode: illegal only in DECODE, then straight to FETCH.
        start("badop", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        cyc("badop_next_fetch", fetch_v);

        // Reset in the middle of a load, held two cycles.
        op = 7'b0000011;
        cyc("mid_decode", dec_v);
        cyc("mid_memadr", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 1'b0));
        rst = 1'b1;
        cyc("mid_reset0", reset_v);
        cyc("mid_reset1", reset_v);
        rst = 1'b0;
        cyc("mid_after_rst_fetch", fetch_v);
        op = 7'b0110011;
        cyc("mid_after_rst_decode", dec_v);

        for (int i = 0; i < 8 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
